// File: rtl/mem_arbiter.sv
// Two-port cache-line arbiter: shares one physical-memory port between the
// instruction and data caches, alternating grants when both sides request together.
module mem_arbiter #(
  parameter int LINE_WIDTH  = 256,
  parameter int OFFSET_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [31:0]           i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [31:0]           d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [31:0]           pmem_addr,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

  state_t state;
  logic   last_grant;
  logic   d_req;
  logic   grant_d;
  logic [31:0] i_line_addr;
  logic [31:0] d_line_addr;
  logic [2*OFFSET_BITS-1:0] unused_offset;

  assign i_line_addr   = {i_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign d_line_addr   = {d_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign unused_offset = {i_addr[OFFSET_BITS-1:0], d_addr[OFFSET_BITS-1:0]};

  // last_grant is 1 after a D grant; on a tie the side not granted last wins
  always_comb begin
    d_req   = d_read | d_write;
    grant_d = d_req & (~i_read | ~last_grant);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
      pmem_addr  <= '0;
      pmem_wdata <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_resp     <= 1'b0;
      d_resp     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state      <= SERVE_D;
            last_grant <= 1'b1;
            pmem_addr  <= d_line_addr;
            pmem_wdata <= d_wdata;
            pmem_write <= d_write;
            pmem_read  <= ~d_write;
          end else if (i_read) begin
            state      <= SERVE_I;
            last_grant <= 1'b0;
            pmem_addr  <= i_line_addr;
            pmem_read  <= 1'b1;
            pmem_write <= 1'b0;
          end
        end
        SERVE_I: begin
          if (pmem_resp) begin
            state     <= DONE;
            pmem_read <= 1'b0;
            i_rdata   <= pmem_rdata;
            i_resp    <= 1'b1;
          end
        end
        SERVE_D: begin
          // the held pmem_read flag doubles as the latched operation type
          if (pmem_resp) begin
            state      <= DONE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            if (pmem_read) begin
              d_rdata <= pmem_rdata;
            end
            d_resp <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          i_resp <= 1'b0;
          d_resp <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a vector table, hand-written corner
// sequences, then randomized traffic against a transaction-level arbitration model.
module tb_mem_arbiter;

  localparam int LW = 256;
  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [31:0]   i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [31:0]   d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [31:0]   pmem_addr;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // transaction-level model state
  logic          next_tie_d;
  logic [LW-1:0] exp_i_rdata;
  logic [LW-1:0] exp_d_rdata;
  logic [31:0]   last_addr;

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [7:0]  wb;
    int          lat;
    logic        exp_d;
    logic        exp_w;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  mem_arbiter #(.LINE_WIDTH(LW), .OFFSET_BITS(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_read     (i_read),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .pmem_rdata (pmem_rdata),
    .pmem_resp  (pmem_resp)
  );

  task automatic checkOutput(input string name, input logic [LW-1:0] actual,
                             input logic [LW-1:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
  endtask

  function automatic logic [LW-1:0] randLine();
    logic [LW-1:0] r;
    for (int k = 0; k < LW/32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input bit check);
    rst = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; pmem_resp = 1'b0; pmem_rdata = randLine();
    step();
    step();
    if (check) begin
      checkOutput("reset pmem_read",  pmem_read,  0);
      checkOutput("reset pmem_write", pmem_write, 0);
      checkOutput("reset pmem_addr",  pmem_addr,  0);
      checkOutput("reset pmem_wdata", pmem_wdata, 0);
      checkOutput("reset resp",       {i_resp, d_resp}, 0);
      checkOutput("reset i_rdata",    i_rdata, 0);
      checkOutput("reset d_rdata",    d_rdata, 0);
    end
    rst = 1'b1;
    next_tie_d = 1'b1; exp_i_rdata = '0; exp_d_rdata = '0; last_addr = '0;
  endtask

  // Starts from an IDLE cycle with requests driven; ends in the resp cycle.
  task automatic runTxn(input logic exp_d, input logic exp_w, input logic [31:0] exp_addr,
                        input logic [LW-1:0] exp_wdata, input int lat, input bit scramble,
                        input string tag);
    logic [LW-1:0] rd;
    step();
    checkOutput({tag, " grant pmem_read"},  pmem_read,  !exp_w);
    checkOutput({tag, " grant pmem_write"}, pmem_write, exp_w);
    checkOutput({tag, " grant pmem_addr"},  pmem_addr,  exp_addr);
    if (exp_w) checkOutput({tag, " grant pmem_wdata"}, pmem_wdata, exp_wdata);
    next_tie_d = !exp_d;
    last_addr  = exp_addr;
    if (scramble) begin
      if (exp_d) begin
        d_read = 1'b0; d_write = 1'b0; d_addr = $urandom; d_wdata = randLine();
      end else begin
        i_read = 1'b0; i_addr = $urandom;
      end
    end
    for (int k = 0; k < lat; k++) begin
      step();
      checkOutput({tag, " hold op"},   {pmem_read, pmem_write}, {!exp_w, exp_w});
      checkOutput({tag, " hold addr"}, pmem_addr, exp_addr);
      if (exp_w) checkOutput({tag, " hold wdata"}, pmem_wdata, exp_wdata);
      checkOutput({tag, " hold resp"}, {i_resp, d_resp}, 0);
    end
    rd = randLine();
    pmem_rdata = rd;
    pmem_resp  = 1'b1;
    step();
    pmem_resp  = 1'b0;
    pmem_rdata = randLine();
    if (!exp_w) begin
      if (exp_d) exp_d_rdata = rd;
      else       exp_i_rdata = rd;
    end
    checkOutput({tag, " i_resp"},  i_resp, !exp_d);
    checkOutput({tag, " d_resp"},  d_resp, exp_d);
    checkOutput({tag, " pmem idle"}, {pmem_read, pmem_write}, 0);
    checkOutput({tag, " i_rdata"}, i_rdata, exp_i_rdata);
    checkOutput({tag, " d_rdata"}, d_rdata, exp_d_rdata);
  endtask

  task automatic finishIdle(input string tag);
    step();
    checkOutput({tag, " idle resp"}, {i_resp, d_resp}, 0);
    checkOutput({tag, " idle pmem"}, {pmem_read, pmem_write}, 0);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    i_read = v.ir; i_addr = v.ia;
    d_read = v.dr; d_write = v.dw; d_addr = v.da; d_wdata = {32{v.wb}};
    runTxn(v.exp_d, v.exp_w, v.exp_addr, {32{v.wb}}, v.lat, 1'b0, tag);
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    finishIdle(tag);
  endtask

  task automatic newRequest(input logic side_d);
    int op;
    op = $urandom_range(0, 3);
    if (side_d) begin
      d_read  = (op == 1) || (op == 3);
      d_write = (op == 2) || (op == 3);
      d_addr  = $urandom;
      d_wdata = randLine();
    end else begin
      i_read = (op != 0);
      i_addr = $urandom;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic ip, dp, wd, ew;
    logic [31:0] ea;
    logic [LW-1:0] ewd;

    vecs[0] = '{1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0,         8'h00, 4, 1'b0, 1'b0, 32'h0000_1220};
    vecs[1] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_00FF, 8'hA5, 2, 1'b1, 1'b1, 32'h8000_00E0};
    vecs[2] = '{1'b1, 32'h0000_0450, 1'b1, 1'b0, 32'h2000_0047, 8'h00, 1, 1'b0, 1'b0, 32'h0000_0440};
    vecs[3] = '{1'b1, 32'h0000_0460, 1'b1, 1'b1, 32'h1234_567F, 8'h3C, 3, 1'b1, 1'b1, 32'h1234_5660};
    vecs[4] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'hFFFF_FFFF, 8'h00, 0, 1'b1, 1'b0, 32'hFFFF_FFE0};
    vecs[5] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0,         8'h5A, 1, 1'b0, 1'b0, 32'hDEAD_BEE0};

    doReset(1'b1);
    for (int n = 0; n < 6; n++) applyStimulus(vecs[n], n);

    // strict alternation with both sides holding requests, D first after reset
    doReset(1'b0);
    i_read = 1'b1; i_addr = 32'h0000_0100;
    d_read = 1'b1; d_addr = 32'h0000_0200;
    runTxn(1'b1, 1'b0, 32'h0000_0200, '0, 1, 1'b0, "tie1"); finishIdle("tie1");
    runTxn(1'b0, 1'b0, 32'h0000_0100, '0, 0, 1'b0, "tie2"); finishIdle("tie2");
    runTxn(1'b1, 1'b0, 32'h0000_0200, '0, 2, 1'b0, "tie3"); finishIdle("tie3");
    runTxn(1'b0, 1'b0, 32'h0000_0100, '0, 1, 1'b0, "tie4");
    i_read = 1'b0; d_read = 1'b0;
    finishIdle("tie4");

    // request withdrawn and address changed right after grant
    d_read = 1'b1; d_addr = 32'h4000_0033;
    runTxn(1'b1, 1'b0, 32'h4000_0020, '0, 3, 1'b1, "withdraw");
    finishIdle("withdraw");

    // reset during a transaction, then a stale pmem_resp
    i_read = 1'b1; i_addr = 32'h0000_5555;
    step();
    checkOutput("rstmid active", pmem_read, 1);
    i_read = 1'b0; rst = 1'b0;
    step();
    rst = 1'b1;
    next_tie_d = 1'b1; exp_i_rdata = '0; exp_d_rdata = '0;
    checkOutput("rstmid pmem_read", pmem_read, 0);
    checkOutput("rstmid pmem_addr", pmem_addr, 0);
    checkOutput("rstmid resp", {i_resp, d_resp}, 0);
    pmem_resp = 1'b1; pmem_rdata = randLine();
    step();
    pmem_resp = 1'b0;
    checkOutput("rstmid stale resp", {i_resp, d_resp}, 0);
    checkOutput("rstmid stale pmem", {pmem_read, pmem_write}, 0);
    checkOutput("rstmid i_rdata", i_rdata, exp_i_rdata);
    step();
    checkOutput("rstmid later resp", {i_resp, d_resp}, 0);
    i_read = 1'b1; i_addr = 32'h0000_0A00;
    d_read = 1'b1; d_addr = 32'h0000_0B00;
    runTxn(1'b1, 1'b0, 32'h0000_0B00, '0, 0, 1'b0, "rstmid tie");
    i_read = 1'b0; d_read = 1'b0;
    finishIdle("rstmid tie");

    // spurious pmem_resp while idle
    pmem_resp = 1'b1; pmem_rdata = randLine();
    step();
    pmem_resp = 1'b0;
    step();
    checkOutput("spurious resp", {i_resp, d_resp}, 0);
    checkOutput("spurious pmem", {pmem_read, pmem_write}, 0);
    checkOutput("spurious addr", pmem_addr, last_addr);
    checkOutput("spurious i_rdata", i_rdata, exp_i_rdata);
    checkOutput("spurious d_rdata", d_rdata, exp_d_rdata);

    // randomized traffic against the arbitration model
    doReset(1'b0);
    for (int t = 0; t < 60; t++) begin
      if (!i_read && !(d_read || d_write)) begin
        if ($urandom_range(0, 1) == 1) begin d_read = 1'b1; d_addr = $urandom; end
        else begin i_read = 1'b1; i_addr = $urandom; end
      end
      ip = i_read;
      dp = d_read | d_write;
      wd = (ip && dp) ? next_tie_d : dp;
      if (wd) begin
        ew = d_write; ea = d_addr & LINE_MASK; ewd = d_wdata;
      end else begin
        ew = 1'b0; ea = i_addr & LINE_MASK; ewd = '0;
      end
      runTxn(wd, ew, ea, ewd, $urandom_range(0, 4), bit'($urandom_range(0, 1)), "rnd");
      newRequest(wd);
      finishIdle("rnd");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
